// File: rtl/border_frame_ctrl.sv
// Frame buffer controller: loads one raster frame, presents it to an external datapath, drains the result.
// Optional build macro BORDER_FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module border_frame_ctrl #(
  parameter int WIDTH    = 9,
  parameter int HEIGHT   = 9,
  parameter int PROC_LAT = 1,
  localparam int SIZE    = WIDTH * HEIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [7:0] dp_in  [0:SIZE-1],
  input  logic [7:0] dp_out [0:SIZE-1],
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       m_last,
  output logic       busy
`ifdef BORDER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);
  localparam logic [3:0]       WCNT_END = 4'(PROC_LAT);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PROC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             s_ready_q, s_ready_d;
  logic [7:0]       in_buf_q  [0:SIZE-1];
  logic [7:0]       in_buf_d  [0:SIZE-1];
  logic [7:0]       res_buf_q [0:SIZE-1];
  logic [7:0]       res_buf_d [0:SIZE-1];
`ifdef BORDER_FRAME_CNT_EN
  logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

  // Next-state, index/wait counters and buffer updates for the LOAD/PROC/DRAIN sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    in_buf_d  = in_buf_q;
    res_buf_d = res_buf_q;
`ifdef BORDER_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    case (state_q)
      LOAD: begin
        if (s_valid && s_ready_q) begin
          in_buf_d[idx_q] = s_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = IDX_ZERO;
            wcnt_d  = 4'd0;
            state_d = PROC;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      PROC: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == WCNT_END) begin
          res_buf_d = dp_out;
          state_d   = DRAIN;
        end else begin
          state_d = PROC;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = IDX_ZERO;
            state_d = LOAD;
`ifdef BORDER_FRAME_CNT_EN
            frame_cnt_d = frame_cnt_q + 16'd1;
`endif
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = IDX_ZERO;
        wcnt_d  = 4'd0;
      end
    endcase
    // s_ready is registered so it never depends combinationally on the stream inputs.
    s_ready_d = (state_d == LOAD);
  end

  // State and buffer registers with synchronous reset that discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      idx_q     <= IDX_ZERO;
      wcnt_q    <= 4'd0;
      s_ready_q <= 1'b0;
      in_buf_q  <= '{default: 8'd0};
      res_buf_q <= '{default: 8'd0};
`ifdef BORDER_FRAME_CNT_EN
      frame_cnt_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      s_ready_q <= s_ready_d;
      in_buf_q  <= in_buf_d;
      res_buf_q <= res_buf_d;
`ifdef BORDER_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign s_ready = s_ready_q;
  assign dp_in   = in_buf_q;
  assign m_valid = (state_q == DRAIN);
  assign m_data  = (state_q == DRAIN) ? res_buf_q[idx_q] : 8'd0;
  assign m_last  = (state_q == DRAIN) && (idx_q == IDX_LAST);
  assign busy    = !((state_q == LOAD) && (idx_q == IDX_ZERO));
`ifdef BORDER_FRAME_CNT_EN
  assign frame_cnt = frame_cnt_q;
`endif

endmodule
